sensor_freq_meter: RTL and testbench

Parametrised sensor frequency meter. It synchronises an asynchronous sensor pulse train into the `clk` domain and produces periodic measurement results in one of two modes:
- **period mode:** `clk` cycles spanning AVG sensor periods.
- **gate mode:** sensor rising edges counted in a fixed GATE-cycle window.

Results carry a one-cycle valid strobe plus saturation and no-signal status. Downstream logic converts the results to frequency; this block contains no divider.

---
 rtl/sensor_pkg.sv | 20 ++
 rtl/sensor_sync_edge.sv | 30 +++
 rtl/sensor_freq_meter.sv | 161 ++++++++++++++++
 tb/tb_sensor_freq_meter.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sensor_pkg.sv
// Shared types and helpers for the sensor frequency meter family.
package sensor_pkg;

  // States of the period-mode measurement FSM.
  typedef enum logic {
    WAIT    = 1'b0,
    MEASURE = 1'b1
  } period_state_e;

  // Values of the mode input.
  localparam logic PERIOD_MODE = 1'b0;
  localparam logic GATE_MODE   = 1'b1;

  // Increment that sticks at limit instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input logic [31:0] limit);
    return (value >= limit) ? limit : value + 32'd1;
  endfunction

endpackage

// File: rtl/sensor_sync_edge.sv
// Three-flop synchroniser for an asynchronous pulse input with rising-edge detect.
// All stages reset to 1 so an input that is already high at reset is not
// mistaken for a fresh rising edge.
module sensor_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic sensor,
  output logic rise
);

  logic [2:0] sync_q;
  logic [2:0] sync_d;

  // Shift the raw input through the chain; bit 0 is the metastability catcher.
  always_comb begin
    sync_d = {sync_q[1:0], sensor};
  end

  // Synchroniser chain register, preset high on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 3'b111;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign rise = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/sensor_freq_meter.sv
// Sensor frequency meter: period mode times AVG sensor periods in clk cycles,
// gate mode counts sensor edges in a fixed window of GATE clk cycles.
module sensor_freq_meter
  import sensor_pkg::*;
#(
  parameter int unsigned CNT_W  = 24,
  parameter int unsigned EDGE_W = 8,
  parameter int unsigned AVG    = 4,
  parameter int unsigned GATE   = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sensor,
  input  logic              mode,
  output logic [CNT_W-1:0]  cycles,
  output logic [EDGE_W-1:0] edges,
  output logic              valid,
  output logic              overflow,
  output logic              no_signal
);

  localparam logic [CNT_W-1:0]  CNT_MAX     = '1;
  localparam logic [CNT_W-1:0]  GATE_LAST   = CNT_W'(GATE - 1);
  localparam logic [CNT_W-1:0]  GATE_CYCLES = CNT_W'(GATE);
  localparam logic [EDGE_W-1:0] EDGE_MAX    = '1;
  localparam logic [EDGE_W-1:0] AVG_LAST    = EDGE_W'(AVG - 1);
  localparam logic [EDGE_W-1:0] AVG_EDGES   = EDGE_W'(AVG);

  logic rise;

  period_state_e     state_q, state_d;
  logic              mode_q, mode_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  gcnt_q, gcnt_d;
  logic [EDGE_W-1:0] ecnt_q, ecnt_d;
  logic              sat_q, sat_d;
  logic [CNT_W-1:0]  cycles_q, cycles_d;
  logic [EDGE_W-1:0] edges_q, edges_d;
  logic              valid_q, valid_d;
  logic              overflow_q, overflow_d;
  logic              no_signal_q, no_signal_d;
  logic [EDGE_W-1:0] gate_ecnt;
  logic              gate_sat;

  sensor_sync_edge u_sync (
    .clk    (clk),
    .rst    (rst),
    .sensor (sensor),
    .rise   (rise)
  );

  // Next-state logic for both measurement modes, the mode-change abort and the result registers.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode;
    cnt_d       = cnt_q;
    gcnt_d      = gcnt_q;
    ecnt_d      = ecnt_q;
    sat_d       = sat_q;
    cycles_d    = cycles_q;
    edges_d     = edges_q;
    valid_d     = 1'b0;
    overflow_d  = overflow_q;
    no_signal_d = no_signal_q;
    gate_ecnt   = rise ? EDGE_W'(sat_inc(32'(ecnt_q), 32'(EDGE_MAX))) : ecnt_q;
    gate_sat    = sat_q | (rise & (ecnt_q == EDGE_MAX));

    if (mode != mode_q) begin
      state_d = WAIT;
      cnt_d   = '0;
      gcnt_d  = '0;
      ecnt_d  = '0;
      sat_d   = 1'b0;
    end else if (mode_q == GATE_MODE) begin
      if (gcnt_q == GATE_LAST) begin
        cycles_d    = GATE_CYCLES;
        edges_d     = gate_ecnt;
        valid_d     = 1'b1;
        overflow_d  = gate_sat;
        no_signal_d = (gate_ecnt == '0);
        gcnt_d      = '0;
        ecnt_d      = '0;
        sat_d       = 1'b0;
      end else begin
        gcnt_d = gcnt_q + CNT_W'(1);
        ecnt_d = gate_ecnt;
        sat_d  = gate_sat;
      end
    end else begin
      case (state_q)
        WAIT: begin
          if (rise) begin
            state_d = MEASURE;
            cnt_d   = CNT_W'(1);
            ecnt_d  = '0;
          end
        end
        MEASURE: begin
          if (rise && (ecnt_q == AVG_LAST)) begin
            cycles_d    = cnt_q;
            edges_d     = AVG_EDGES;
            valid_d     = 1'b1;
            overflow_d  = 1'b0;
            no_signal_d = 1'b0;
            cnt_d       = CNT_W'(1);
            ecnt_d      = '0;
          end else if (cnt_q == CNT_MAX) begin
            no_signal_d = 1'b1;
            state_d     = WAIT;
            cnt_d       = '0;
            ecnt_d      = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
            if (rise) begin
              ecnt_d = ecnt_q + EDGE_W'(1);
            end
          end
        end
        default: begin
          state_d = WAIT;
        end
      endcase
    end
  end

  // State, counter and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= WAIT;
      mode_q      <= mode;
      cnt_q       <= '0;
      gcnt_q      <= '0;
      ecnt_q      <= '0;
      sat_q       <= 1'b0;
      cycles_q    <= '0;
      edges_q     <= '0;
      valid_q     <= 1'b0;
      overflow_q  <= 1'b0;
      no_signal_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      cnt_q       <= cnt_d;
      gcnt_q      <= gcnt_d;
      ecnt_q      <= ecnt_d;
      sat_q       <= sat_d;
      cycles_q    <= cycles_d;
      edges_q     <= edges_d;
      valid_q     <= valid_d;
      overflow_q  <= overflow_d;
      no_signal_q <= no_signal_d;
    end
  end

  assign cycles    = cycles_q;
  assign edges     = edges_q;
  assign valid     = valid_q;
  assign overflow  = overflow_q;
  assign no_signal = no_signal_q;

endmodule

// File: tb/tb_sensor_freq_meter.sv
// Testbench for sensor_freq_meter with a result scoreboard and a vector table.
module tb_sensor_freq_meter;

  localparam int CNT_W  = 8;
  localparam int EDGE_W = 4;
  localparam int AVG    = 4;
  localparam int GATE   = 100;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              sensor = 1'b0;
  logic              mode = 1'b0;
  logic [CNT_W-1:0]  cycles;
  logic [EDGE_W-1:0] edges;
  logic              valid;
  logic              overflow;
  logic              no_signal;

  sensor_freq_meter #(
    .CNT_W  (CNT_W),
    .EDGE_W (EDGE_W),
    .AVG    (AVG),
    .GATE   (GATE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sensor    (sensor),
    .mode      (mode),
    .cycles    (cycles),
    .edges     (edges),
    .valid     (valid),
    .overflow  (overflow),
    .no_signal (no_signal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CNT_W-1:0]  cycles;
    logic [EDGE_W-1:0] edges;
    logic              overflow;
    logic              no_signal;
    int                interval;
  } result_t;

  typedef struct {
    string             name;
    logic              mode;
    int                period;
    int                high;
    int                count;
    logic [CNT_W-1:0]  cycles;
    logic [EDGE_W-1:0] edges;
    logic              overflow;
    logic              no_signal;
    int                interval;
  } vector_t;

  result_t exp_q[$];
  vector_t vecs[7];
  int      checks = 0;
  int      errors = 0;
  int      valid_count = 0;
  int      cyc = 0;
  int      last_valid_cyc = 0;
  bit      sb_enable = 1'b0;
  int      gen_period = 0;
  int      gen_high = 0;
  int      gen_phase = 0;
  logic    gen_level = 1'b0;

  // Sensor waveform generator: period 0 holds gen_level, otherwise a square wave.
  initial begin
    forever begin
      @(negedge clk);
      if (gen_period == 0) begin
        sensor    = gen_level;
        gen_phase = 0;
      end else begin
        sensor    = (gen_phase < gen_high);
        gen_phase = (gen_phase + 1 >= gen_period) ? 0 : gen_phase + 1;
      end
    end
  end

  // Scoreboard monitor: every valid pops one expected result and compares it.
  initial begin
    result_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (valid) begin
        valid_count++;
        if (sb_enable) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_valid: got valid with cycles=%0d edges=%0d, expected no valid",
                     cycles, edges);
          end else begin
            e = exp_q.pop_front();
            if (cycles !== e.cycles || edges !== e.edges ||
                overflow !== e.overflow || no_signal !== e.no_signal) begin
              errors++;
              $display("[TB] FAIL result: got cycles=%0d edges=%0d ovf=%0b nosig=%0b, expected cycles=%0d edges=%0d ovf=%0b nosig=%0b",
                       cycles, edges, overflow, no_signal, e.cycles, e.edges, e.overflow, e.no_signal);
            end
            if (e.interval != 0) begin
              checks++;
              if (cyc - last_valid_cyc != e.interval) begin
                errors++;
                $display("[TB] FAIL valid_interval: got %0d, expected %0d",
                         cyc - last_valid_cyc, e.interval);
              end
            end
          end
        end
        last_valid_cyc = cyc;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pushResult(input int c, input int e, input logic o,
                            input logic n, input int iv);
    result_t r;
    r.cycles    = c[CNT_W-1:0];
    r.edges     = e[EDGE_W-1:0];
    r.overflow  = o;
    r.no_signal = n;
    r.interval  = iv;
    exp_q.push_back(r);
  endtask

  task automatic drainQueue(input string name, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL %s: %0d results still pending after %0d cycles, expected 0",
               name, exp_q.size(), budget);
      exp_q.delete();
    end
    sb_enable = 1'b0;
  endtask

  task automatic skipValids(input string name, input int k, input int budget);
    int target;
    target = valid_count + k;
    for (int i = 0; i < budget && valid_count < target; i++) @(negedge clk);
    checkOutput(name, 32'(valid_count >= target), 32'd1);
  endtask

  task automatic restartGen(input int period, input int high);
    gen_period = 0;
    gen_level  = 1'b0;
    repeat (5) @(negedge clk);
    gen_high   = high;
    gen_period = period;
  endtask

  task automatic applyStimulus(input vector_t v);
    sb_enable  = 1'b0;
    gen_period = 0;
    gen_level  = 1'b0;
    mode       = v.mode;
    doReset();
    repeat (3) @(negedge clk);
    gen_high   = v.high;
    gen_period = v.period;
    sb_enable  = 1'b1;
    for (int i = 0; i < v.count; i++) begin
      pushResult(int'(v.cycles), int'(v.edges), v.overflow, v.no_signal,
                 (i == 0) ? 0 : v.interval);
    end
    drainQueue(v.name, v.count * (v.interval + 60) + 100);
  endtask

  function automatic vector_t mk(input string name, input logic m, input int p,
                                 input int h, input int cnt, input int c,
                                 input int e, input logic o, input logic ns,
                                 input int iv);
    vector_t v;
    v.name      = name;
    v.mode      = m;
    v.period    = p;
    v.high      = h;
    v.count     = cnt;
    v.cycles    = c[CNT_W-1:0];
    v.edges     = e[EDGE_W-1:0];
    v.overflow  = o;
    v.no_signal = ns;
    v.interval  = iv;
    return v;
  endfunction

  // Hard stop in case a wait loop is broken.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int vc;

    vecs[0] = mk("period_p10",  1'b0, 10, 5, 3, 40,  4,  1'b0, 1'b0, 40);
    vecs[1] = mk("period_p8",   1'b0, 8,  4, 2, 32,  4,  1'b0, 1'b0, 32);
    vecs[2] = mk("period_p14",  1'b0, 14, 7, 2, 56,  4,  1'b0, 1'b0, 56);
    vecs[3] = mk("gate_p10",    1'b1, 10, 5, 2, 100, 10, 1'b0, 1'b0, 100);
    vecs[4] = mk("gate_p20",    1'b1, 20, 10, 2, 100, 5, 1'b0, 1'b0, 100);
    vecs[5] = mk("gate_low",    1'b1, 0,  0, 2, 100, 0,  1'b0, 1'b1, 100);
    vecs[6] = mk("gate_sat_p4", 1'b1, 4,  2, 2, 100, 15, 1'b1, 1'b0, 100);

    // Reset values.
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkOutput("reset_cycles", 32'(cycles), 32'd0);
    checkOutput("reset_edges", 32'(edges), 32'd0);
    checkOutput("reset_valid", 32'(valid), 32'd0);
    checkOutput("reset_overflow", 32'(overflow), 32'd0);
    checkOutput("reset_no_signal", 32'(no_signal), 32'd0);

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Empty window right after a saturated one clears overflow and flags no signal.
    gen_period = 0;
    gen_level  = 1'b0;
    skipValids("skip_after_sat", 1, 150);
    sb_enable = 1'b1;
    pushResult(100, 0, 1'b0, 1'b1, 100);
    drainQueue("gate_empty_after_sat", 250);

    // Saturate again, then switch to period mode: overflow held until the period valid clears it.
    restartGen(4, 2);
    skipValids("skip_resat", 1, 150);
    sb_enable = 1'b1;
    pushResult(100, 15, 1'b1, 1'b0, 100);
    drainQueue("gate_resat", 250);
    gen_period = 0;
    repeat (5) @(negedge clk);
    checkOutput("ovf_before_switch", 32'(overflow), 32'd1);
    mode = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("ovf_held_after_abort", 32'(overflow), 32'd1);
    gen_high   = 5;
    gen_period = 10;
    sb_enable  = 1'b1;
    pushResult(40, 4, 1'b0, 1'b0, 0);
    pushResult(40, 4, 1'b0, 1'b0, 40);
    drainQueue("period_after_gate", 300);

    // Single rise then silence: timeout after the counter reaches its maximum.
    gen_period = 0;
    gen_level  = 1'b0;
    doReset();
    repeat (5) @(negedge clk);
    vc = valid_count;
    @(posedge clk);
    #2;
    gen_level = 1'b1;
    n = 0;
    while (n < 400 && no_signal !== 1'b1) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 5) gen_level = 1'b0;
    end
    checkOutput("timeout_latency", 32'(n), 32'd258);
    checkOutput("timeout_no_valid", 32'(valid_count - vc), 32'd0);
    @(negedge clk);
    gen_high   = 5;
    gen_period = 10;
    sb_enable  = 1'b1;
    pushResult(40, 4, 1'b0, 1'b0, 0);
    drainQueue("recover_after_timeout", 300);

    // Mode toggle 20 cycles into a period measurement.
    repeat (20) @(negedge clk);
    sb_enable = 1'b1;
    pushResult(100, 10, 1'b0, 1'b0, 0);
    mode = 1'b1;
    n = 0;
    while (n < 200 && valid !== 1'b1) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 50) begin
        checkOutput("held_cycles", 32'(cycles), 32'd40);
        checkOutput("held_edges", 32'(edges), 32'd4);
      end
    end
    checkOutput("gate_first_valid_after_switch", 32'(n), 32'd101);
    drainQueue("gate_after_switch", 20);

    // Reset mid-window with the sensor held high across reset.
    gen_period = 0;
    gen_level  = 1'b1;
    repeat (10) @(negedge clk);
    mode = 1'b0;
    doReset();
    checkOutput("midrst_cycles", 32'(cycles), 32'd0);
    checkOutput("midrst_edges", 32'(edges), 32'd0);
    checkOutput("midrst_valid", 32'(valid), 32'd0);
    checkOutput("midrst_overflow", 32'(overflow), 32'd0);
    checkOutput("midrst_no_signal", 32'(no_signal), 32'd0);
    vc = valid_count;
    repeat (300) @(negedge clk);
    checkOutput("no_false_rise", 32'(no_signal), 32'd0);
    checkOutput("no_valid_while_high", 32'(valid_count - vc), 32'd0);
    restartGen(10, 5);
    sb_enable = 1'b1;
    pushResult(40, 4, 1'b0, 1'b0, 0);
    drainQueue("period_after_midrst", 300);

    // First gate valid timing after reset release.
    gen_period = 0;
    gen_level  = 1'b0;
    mode = 1'b1;
    repeat (3) @(negedge clk);
    sb_enable = 1'b1;
    pushResult(100, 0, 1'b0, 1'b1, 0);
    doReset();
    n = 0;
    while (n < 200 && valid !== 1'b1) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("gate_first_valid_after_reset", 32'(n), 32'd100);
    drainQueue("gate_after_reset", 20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
